exp3_sweep_ctrl: RTL and testbench
==================================

# exp3_sweep_ctrl

Sequential truth-table sweeper for the four-input lab function F = A·B' + A'·B·(C+D).
- Owns one instance of the combinational evaluator and steps it through all 16 input combinations, {A,B,C,D} = 0..15.
- After a programmable settle time per vector, it captures F into a 16-bit truth-table register and compares each bit against an expected mask.
- Reports pass/fail, mismatch count and first failing index, so the lab bench or a board-level self-test can check the evaluator without hand-driven switches.

## Interface
Parameters:
- SETTLE, 1, idle cycles each vector is held before F is sampled; legal range 0..7.

Ports:
- clk  in  1  rising-edge clock; the only clock.
- rst_n  in  1  reset, asynchronous assert, active-low.
- start  in  1  launch a sweep; honoured only in IDLE or DONE.
- abort  in  1  cancel the sweep in progress; wins over start.
- expected  in  16  golden mask; bit i is the expected F for {A,B,C,D}=i. Sampled once, on the start edge.
- abcd  out  4  vector currently applied to the evaluator; A is the MSB.
- f_obs  out  1  live evaluator output, for probing.
- busy  out  1  high while a sweep is in progress.
- done  out  1  level; high in DONE until the next accepted start or reset.
- table_q  out  16  captured F values; bit i holds F for vector i.
- pass  out  1  high when table_q == latched expected; valid while done=1.
- mismatch_cnt  out  5  number of differing bits, 0..16.
- first_fail  out  4  lowest failing index; 0 when mismatch_cnt=0.

## Operation
- States: IDLE, SETTLE, SAMPLE, DONE.
- Reset values, all outputs: busy=0, done=0, abcd=0, table_q=0, pass=0, mismatch_cnt=0, first_fail=0. State resets to IDLE.
- **IDLE/DONE + start (abort=0):**
  - latch expected;
  - clear table_q, mismatch_cnt and first_fail;
  - set abcd=0, busy=1, done=0;
  - go to SETTLE (or to SAMPLE when SETTLE=0) and load the settle counter with SETTLE.
- **SETTLE:** decrement the counter each cycle. When it reaches 1, go to SAMPLE. abcd is held constant throughout.
- **SAMPLE (one cycle):**
  - write table_q[abcd] = F;
  - on a mismatch against expected[abcd], increment mismatch_cnt;
  - on the first mismatch only, load first_fail = abcd.
  - If abcd == 15: go to DONE with busy=0, done=1, and pass = (mismatch_cnt after this update == 0).
  - Otherwise: abcd += 1, reload the counter, and return to SETTLE (or stay in SAMPLE when SETTLE=0).
- abcd never wraps during a sweep; 15 is the terminal index.
- **abort** in SETTLE or SAMPLE: go to IDLE next edge.
  - busy=0, done=0, abcd=0.
  - table_q and mismatch_cnt keep the partial results; pass=0.
- **abort** in IDLE or DONE: no effect on results. start in the same cycle is ignored.
- start while busy: ignored.
- expected changing mid-sweep: no effect.
- Asynchronous reset mid-sweep: all registers return to reset values immediately; no partial done.

## Timing
- start sampled at edge k → abcd=0 and busy=1 visible after edge k.
- Each vector occupies SETTLE+1 cycles. The capture for vector i occurs at edge k + (i+1)·(SETTLE+1).
- done rises after edge k + 16·(SETTLE+1): edge k+32 for SETTLE=1, edge k+16 for SETTLE=0.
- table_q, mismatch_cnt and first_fail update on the capture edge. pass becomes valid together with done.
- Back-to-back sweeps: start asserted while done=1 relaunches at that edge, with no IDLE cycle.
- f_obs is combinational from abcd; there is no register between abcd and the evaluator.

## Structure
- Shared package exp3_pkg holds:
  - the state enum (IDLE, SETTLE, SAMPLE, DONE);
  - VEC_COUNT = 16;
  - GOLDEN_F = 16'h0FE0, the reference truth table with ones at indices 5–11.
- One sub-module, exp3_f: the pure combinational evaluator, ports A, B, C, D, F. The controller instantiates it once and drives A..D from abcd[3:0].
- All counting and comparison live in the controller. The settle counter is 3 bits wide.

## Test plan
- Reset: hold rst_n=0 and pulse clk → every output 0, state IDLE. Release reset → outputs stay 0 with start=0.
- Golden sweep, SETTLE=1, expected=16'h0FE0, start at edge k → done=1 after edge k+32, table_q=16'h0FE0, pass=1, mismatch_cnt=0, first_fail=0.
- Single error, expected=16'h0FE1 → table_q=16'h0FE0, pass=0, mismatch_cnt=1, first_fail=0. Then, with expected=16'h0BE0 → mismatch_cnt=1, first_fail=10.
- Inverted mask, expected=16'hF01F → mismatch_cnt=16, first_fail=0, pass=0. Restart with start while done=1 → abcd=0 and busy=1 on that edge.
- Abort while abcd=7 → busy=0 and done=0 next cycle, abcd=0. A following start with 16'h0FE0 runs a clean full sweep and gives pass=1. Assert start and abort together while busy → abort wins.
- SETTLE=0 build: done rises after edge k+16 with results identical to the golden sweep. Assert rst_n=0 mid-sweep → outputs clear asynchronously, before the next clk edge.

Source files
------------

// File: rtl/exp3_pkg.sv
// Shared types and constants for the four-input lab function sweeper.
package exp3_pkg;

    // Sweep controller states
    typedef enum logic [1:0] {
        StIdle,
        StSettle,
        StSample,
        StDone
    } state_e;

    localparam int unsigned VEC_COUNT = 16;
    localparam logic [3:0]  LAST_VEC  = 4'(VEC_COUNT - 1);

    // Reference truth table of F = A.B' + A'.B.(C+D); ones at indices 5..11
    localparam logic [15:0] GOLDEN_F  = 16'h0FE0;

endpackage

// File: rtl/exp3_f.sv
// Pure combinational evaluator for F = A.B' + A'.B.(C+D).
module exp3_f (
    input  logic A,
    input  logic B,
    input  logic C,
    input  logic D,
    output logic F
);

    assign F = (A & ~B) | (~A & B & (C | D));

endmodule

// File: rtl/exp3_sweep_ctrl.sv
// Steps the evaluator through all 16 input vectors, captures F into a truth
// table and scores it against a golden mask latched at start.
module exp3_sweep_ctrl
    import exp3_pkg::*;
#(
    parameter int unsigned SETTLE = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic [15:0] expected,
    output logic [3:0]  abcd,
    output logic        f_obs,
    output logic        busy,
    output logic        done,
    output logic [15:0] table_q,
    output logic        pass,
    output logic [4:0]  mismatch_cnt,
    output logic [3:0]  first_fail
);

    localparam logic [2:0] SettleLoad = 3'(SETTLE);
    // With no settle time every vector goes straight to the capture state
    localparam state_e     FirstSt    = (SETTLE == 0) ? StSample : StSettle;

    state_e      state_q;
    logic [2:0]  cnt_q;
    logic [15:0] exp_q;
    logic        bit_mis;
    logic [4:0]  cnt_upd;

    exp3_f u_f (
        .A (abcd[3]),
        .B (abcd[2]),
        .C (abcd[1]),
        .D (abcd[0]),
        .F (f_obs)
    );

    // Score the live evaluator output against the latched golden bit
    always_comb begin
        bit_mis = f_obs ^ exp_q[abcd];
        cnt_upd = mismatch_cnt + {4'd0, bit_mis};
    end

    // Sweep FSM with registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            cnt_q        <= 3'd0;
            exp_q        <= 16'd0;
            abcd         <= 4'd0;
            busy         <= 1'b0;
            done         <= 1'b0;
            table_q      <= 16'd0;
            pass         <= 1'b0;
            mismatch_cnt <= 5'd0;
            first_fail   <= 4'd0;
        end else begin
            case (state_q)
                StIdle, StDone: begin
                    // abort in an idle state suppresses start but leaves results alone
                    if (start && !abort) begin
                        exp_q        <= expected;
                        table_q      <= 16'd0;
                        mismatch_cnt <= 5'd0;
                        first_fail   <= 4'd0;
                        abcd         <= 4'd0;
                        busy         <= 1'b1;
                        done         <= 1'b0;
                        pass         <= 1'b0;
                        cnt_q        <= SettleLoad;
                        state_q      <= FirstSt;
                    end
                end
                StSettle: begin
                    if (abort) begin
                        state_q <= StIdle;
                        busy    <= 1'b0;
                        done    <= 1'b0;
                        abcd    <= 4'd0;
                        pass    <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - 3'd1;
                        if (cnt_q == 3'd1) begin
                            state_q <= StSample;
                        end
                    end
                end
                StSample: begin
                    if (abort) begin
                        state_q <= StIdle;
                        busy    <= 1'b0;
                        done    <= 1'b0;
                        abcd    <= 4'd0;
                        pass    <= 1'b0;
                    end else begin
                        table_q[abcd] <= f_obs;
                        if (bit_mis) begin
                            mismatch_cnt <= cnt_upd;
                            if (mismatch_cnt == 5'd0) begin
                                first_fail <= abcd;
                            end
                        end
                        if (abcd == LAST_VEC) begin
                            state_q <= StDone;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            pass    <= (cnt_upd == 5'd0);
                        end else begin
                            abcd    <= abcd + 4'd1;
                            cnt_q   <= SettleLoad;
                            state_q <= FirstSt;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_exp3_sweep_ctrl.sv
// Scoreboard bench for exp3_sweep_ctrl: one instance with SETTLE=1, one with SETTLE=0.
module tb_exp3_sweep_ctrl;

    typedef struct {
        logic [15:0] tbl;
        logic        pass;
        logic [4:0]  cnt;
        logic [3:0]  ff;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [15:0] expected;
    logic        start_1, abort_1, start_0, abort_0;

    logic [3:0]  abcd_1, abcd_0;
    logic        f_obs_1, f_obs_0, busy_1, busy_0, done_1, done_0, pass_1, pass_0;
    logic [15:0] table_1, table_0;
    logic [4:0]  cnt_1, cnt_0;
    logic [3:0]  ff_1, ff_0;

    // Selected-instance view: sel=1 -> SETTLE=1 instance, sel=0 -> SETTLE=0 instance
    bit          sel;
    logic [3:0]  abcd_s, ff_s;
    logic        f_obs_s, busy_s, done_s, pass_s;
    logic [15:0] table_s;
    logic [4:0]  cnt_s;

    int   checks;
    int   failures;
    exp_t sb_q[$];

    exp3_sweep_ctrl #(.SETTLE(1)) u_dut1 (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start_1),
        .abort        (abort_1),
        .expected     (expected),
        .abcd         (abcd_1),
        .f_obs        (f_obs_1),
        .busy         (busy_1),
        .done         (done_1),
        .table_q      (table_1),
        .pass         (pass_1),
        .mismatch_cnt (cnt_1),
        .first_fail   (ff_1)
    );

    exp3_sweep_ctrl #(.SETTLE(0)) u_dut0 (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start_0),
        .abort        (abort_0),
        .expected     (expected),
        .abcd         (abcd_0),
        .f_obs        (f_obs_0),
        .busy         (busy_0),
        .done         (done_0),
        .table_q      (table_0),
        .pass         (pass_0),
        .mismatch_cnt (cnt_0),
        .first_fail   (ff_0)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always_comb begin
        if (sel) begin
            abcd_s = abcd_1; ff_s = ff_1; f_obs_s = f_obs_1; busy_s = busy_1;
            done_s = done_1; pass_s = pass_1; table_s = table_1; cnt_s = cnt_1;
        end else begin
            abcd_s = abcd_0; ff_s = ff_0; f_obs_s = f_obs_0; busy_s = busy_0;
            done_s = done_0; pass_s = pass_0; table_s = table_0; cnt_s = cnt_0;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic model_f(input int i);
        logic [3:0] v;
        v = 4'(i);
        return (v[3] & ~v[2]) | (~v[3] & v[2] & (v[1] | v[0]));
    endfunction

    function automatic exp_t model(input logic [15:0] mask);
        exp_t r;
        r.tbl = 16'd0;
        r.cnt = 5'd0;
        r.ff  = 4'd0;
        for (int i = 0; i < 16; i++) begin
            r.tbl[i] = model_f(i);
            if (r.tbl[i] != mask[i]) begin
                if (r.cnt == 5'd0) r.ff = 4'(i);
                r.cnt = r.cnt + 5'd1;
            end
        end
        r.pass = (r.cnt == 5'd0);
        return r;
    endfunction

    task automatic set_start(input logic v);
        if (sel) start_1 = v; else start_0 = v;
    endtask

    task automatic set_abort(input logic v);
        if (sel) abort_1 = v; else abort_0 = v;
    endtask

    // Called at a negedge; issues start for one edge and checks launch state
    task automatic drive_start(input logic [15:0] mask, input bit push);
        expected = mask;
        set_start(1'b1);
        if (push) sb_q.push_back(model(mask));
        @(negedge clk);
        set_start(1'b0);
        expected = ~mask;  // mid-sweep changes must have no effect
        check_eq("launch_busy", 32'(busy_s), 32'd1);
        check_eq("launch_abcd", 32'(abcd_s), 32'd0);
        check_eq("launch_done", 32'(done_s), 32'd0);
    endtask

    task automatic wait_done(input int exp_cycles);
        int   cycles;
        exp_t e;
        cycles = 0;
        while (!done_s && cycles < 400) begin
            @(negedge clk);
            cycles++;
        end
        check_eq("done_latency", 32'(cycles), 32'(exp_cycles));
        if (sb_q.size() == 0) begin
            check_eq("sb_nonempty", 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            check_eq("table_q", 32'(table_s), 32'(e.tbl));
            check_eq("pass", 32'(pass_s), 32'(e.pass));
            check_eq("mismatch_cnt", 32'(cnt_s), 32'(e.cnt));
            check_eq("first_fail", 32'(ff_s), 32'(e.ff));
            check_eq("busy_at_done", 32'(busy_s), 32'd0);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_abcd"}, 32'(abcd_s), 32'd0);
        check_eq({tag, "_busy"}, 32'(busy_s), 32'd0);
        check_eq({tag, "_done"}, 32'(done_s), 32'd0);
        check_eq({tag, "_table"}, 32'(table_s), 32'd0);
        check_eq({tag, "_pass"}, 32'(pass_s), 32'd0);
        check_eq({tag, "_cnt"}, 32'(cnt_s), 32'd0);
        check_eq({tag, "_ff"}, 32'(ff_s), 32'd0);
    endtask

    initial begin
        int guard;
        checks   = 0;
        failures = 0;
        sel      = 1'b1;
        rst_n    = 1'b0;
        expected = 16'd0;
        start_1  = 1'b0; abort_1 = 1'b0;
        start_0  = 1'b0; abort_0 = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_all_zero("rst");
        check_eq("rst_f_obs", 32'(f_obs_s), 32'(model_f(0)));
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check_all_zero("post_rst");

        // Golden sweep, SETTLE=1
        drive_start(16'h0FE0, 1'b1);
        wait_done(32);
        check_eq("golden_literal", 32'(table_s), 32'h0FE0);

        // abort+start while done: no effect
        set_abort(1'b1); set_start(1'b1);
        @(negedge clk);
        set_abort(1'b0); set_start(1'b0);
        check_eq("done_abort_done", 32'(done_s), 32'd1);
        check_eq("done_abort_pass", 32'(pass_s), 32'd1);
        check_eq("done_abort_busy", 32'(busy_s), 32'd0);

        // Single-bit errors
        drive_start(16'h0FE1, 1'b1);
        wait_done(32);
        drive_start(16'h0BE0, 1'b1);
        wait_done(32);

        // Inverted mask, then back-to-back relaunch from done
        drive_start(16'hF01F, 1'b1);
        wait_done(32);
        drive_start(16'h0FE0, 1'b1);
        wait_done(32);

        // Abort at vector 7
        drive_start(16'h0FE0, 1'b0);
        guard = 0;
        while (abcd_s != 4'd7 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check_eq("reach_abcd7", 32'(abcd_s), 32'd7);
        check_eq("f_obs_7", 32'(f_obs_s), 32'(model_f(7)));
        set_abort(1'b1);
        @(negedge clk);
        set_abort(1'b0);
        check_eq("abort_busy", 32'(busy_s), 32'd0);
        check_eq("abort_done", 32'(done_s), 32'd0);
        check_eq("abort_abcd", 32'(abcd_s), 32'd0);
        check_eq("abort_pass", 32'(pass_s), 32'd0);
        check_eq("abort_table", 32'(table_s), 32'h0060);
        check_eq("abort_cnt", 32'(cnt_s), 32'd0);
        drive_start(16'h0FE0, 1'b1);
        wait_done(32);

        // start and abort together while busy: abort wins
        drive_start(16'h0FE0, 1'b0);
        repeat (3) @(negedge clk);
        set_abort(1'b1); set_start(1'b1);
        @(negedge clk);
        set_abort(1'b0); set_start(1'b0);
        check_eq("sa_busy", 32'(busy_s), 32'd0);
        check_eq("sa_abcd", 32'(abcd_s), 32'd0);
        @(negedge clk);
        check_eq("sa_stays_idle", 32'(busy_s), 32'd0);

        // SETTLE=0 instance
        sel = 1'b0;
        drive_start(16'h0FE0, 1'b1);
        wait_done(16);
        check_eq("s0_golden_literal", 32'(table_s), 32'h0FE0);

        // Asynchronous reset mid-sweep
        sel = 1'b1;
        drive_start(16'h0FE0, 1'b0);
        repeat (13) @(negedge clk);
        check_eq("pre_rst_busy", 32'(busy_s), 32'd1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("after_rst_done", 32'(done_s), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
